// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream inputs into one output.
// Define PKT_RR_ARB_CNT_EN to add per-port accepted-packet counters on pkt_cnt.
module pkt_rr_arbiter #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_PORTS            = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                          s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                          s_axis_tready,
    input  logic [NUM_PORTS-1:0]                          s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,
    output logic [NUM_PORTS-1:0]                          cur_grant
`ifdef PKT_RR_ARB_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]                       pkt_cnt
`endif
);

    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned IW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        FWD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        cand;
    logic                 found;
    logic                 beat_c;
    logic                 eop_c;

    // Round-robin search starting one past the last served port.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = IW'((32'(last_q) + k + 32'd1) % NUM_PORTS);
            if (!found && s_axis_tvalid[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign beat_c = (state_q == FWD) && s_axis_tvalid[gidx_q] && m_axis_tready;
    assign eop_c  = beat_c && s_axis_tlast[gidx_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        last_d        = last_q;
        s_axis_tready = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = FWD;
                    gidx_d  = sel_idx;
                    grant_d = NUM_PORTS'(1) << sel_idx;
                end
            end
            FWD: begin
                s_axis_tready[gidx_q] = m_axis_tready;
                if (eop_c) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux follows the granted slice without a pipeline stage.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (32'(gidx_q) == i) begin
                m_axis_tdata = s_axis_tdata[i*DW +: DW];
                m_axis_tkeep = s_axis_tkeep[i*KW +: KW];
                m_axis_tuser = s_axis_tuser[i*UW +: UW];
                m_axis_tlast = s_axis_tlast[i];
            end
        end
        m_axis_tvalid = (state_q == FWD) && s_axis_tvalid[gidx_q];
    end

    assign cur_grant = grant_q;

    // Reset leaves port NUM_PORTS-1 as last served so port 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

`ifdef PKT_RR_ARB_CNT_EN
    logic [NUM_PORTS-1:0][31:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (eop_c) begin
            cnt_q[gidx_q] <= cnt_q[gidx_q] + 32'd1;
        end
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: ordering, holding, backpressure, wrap, reset abort, counters.
module tb_pkt_rr_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned UW = 16;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned PW = DW + KW + UW;
    localparam int unsigned BW = PW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [NP-1:0]     s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [NP-1:0]     cur_grant;
`ifdef PKT_RR_ARB_CNT_EN
    logic [NP*32-1:0]  pkt_cnt;
`endif

    pkt_rr_arbiter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS           (NP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .cur_grant    (cur_grant)
`ifdef PKT_RR_ARB_CNT_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    int unsigned len  [NP];
    int unsigned beat [NP];
    int unsigned seq  [NP];
    bit          en   [NP];

    logic [63:0]   vh;
    logic [63:0]   gh;
    logic [63:0]   rh;
    logic [BW-1:0] out_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int unsigned p, input int unsigned s, input int unsigned b);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        d = {8'(32'hA0 + p), 8'(s), 16'(b)};
        k = KW'(b * 5 + p + 1);
        u = UW'(32'hC000 | (p << 8) | (s << 4) | b);
        return {d, k, u};
    endfunction

    function automatic logic [BW-1:0] ebeat(input int unsigned p, input int unsigned b, input int unsigned n);
        return {mk(p, seq[p], b), (b == n - 1)};
    endfunction

    task automatic drive();
        for (int unsigned p = 0; p < NP; p++) begin
            if (len[p] != 0 && en[p]) begin
                s_tvalid[p] = 1'b1;
                {s_tdata[p*DW +: DW], s_tkeep[p*KW +: KW], s_tuser[p*UW +: UW]} = mk(p, seq[p], beat[p]);
                s_tlast[p] = (beat[p] == len[p] - 1);
            end else begin
                s_tvalid[p] = 1'b0;
                s_tlast[p]  = 1'b0;
            end
        end
    endtask

    task automatic load(input int unsigned p, input int unsigned n);
        len[p]  = n;
        beat[p] = 0;
        seq[p]  = seq[p] + 1;
        en[p]   = 1'b1;
    endtask

    task automatic clr();
        vh = '0;
        gh = '0;
        rh = '0;
        out_q.delete();
    endtask

    // One clock: observe on the falling edge, advance sources just after the rising edge.
    task automatic step();
        bit acc[NP];
        @(negedge clk);
        vh = {vh[62:0], m_tvalid};
        gh = {gh[59:0], cur_grant};
        rh = {rh[59:0], s_tready};
        if (m_tvalid && m_tready) out_q.push_back({m_tdata, m_tkeep, m_tuser, m_tlast});
        for (int unsigned p = 0; p < NP; p++) acc[p] = s_tvalid[p] && s_tready[p];
        @(posedge clk);
        #1;
        for (int unsigned p = 0; p < NP; p++) begin
            if (acc[p]) begin
                if (beat[p] == len[p] - 1) len[p] = 0;
                else beat[p] = beat[p] + 1;
            end
        end
        drive();
    endtask

    task automatic chk_out(input int unsigned idx, input int unsigned p, input int unsigned b, input int unsigned n);
        logic [BW-1:0] got;
        got = (idx < out_q.size()) ? out_q[idx] : '0;
        chk($sformatf("beat%0d_p%0d_b%0d", idx, p, b), 64'(got), 64'(ebeat(p, b, n)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        m_tready = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            len[p] = 0; beat[p] = 0; seq[p] = 0; en[p] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(cur_grant), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_sready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // All four ports offer 3-beat packets at once.
        clr();
        for (int unsigned p = 0; p < NP; p++) load(p, 3);
        drive();
        repeat (16) step();
        chk("rr_vhist", 64'(vh[15:0]), 64'h7777);
        chk("rr_ghist", gh, 64'h0111_0222_0444_0888);
        chk("rr_nbeats", 64'(out_q.size()), 64'd12);
        for (int unsigned p = 0; p < NP; p++)
            for (int unsigned b = 0; b < 3; b++) chk_out(p * 3 + b, p, b, 3);

        // Wrap after port 3: ports 0 and 3 with single-beat packets.
        clr();
        load(0, 1);
        load(3, 1);
        drive();
        repeat (4) step();
        chk("wrap_ghist", 64'(gh[15:0]), 64'h0108);
        chk("wrap_nbeats", 64'(out_q.size()), 64'd2);
        chk_out(0, 0, 0, 1);
        chk_out(1, 3, 0, 1);

        // Port 1 requests mid-packet of port 2 and must wait.
        clr();
        load(2, 4);
        drive();
        repeat (3) step();
        load(1, 2);
        drive();
        repeat (5) step();
        chk("hold_ghist", 64'(gh[31:0]), 64'h0444_4022);
        chk("hold_vhist", 64'(vh[7:0]), 64'h7B);
        chk("hold_nbeats", 64'(out_q.size()), 64'd6);
        for (int unsigned b = 0; b < 4; b++) chk_out(b, 2, b, 4);
        for (int unsigned b = 0; b < 2; b++) chk_out(4 + b, 1, b, 2);

        // Output backpressure toggling 1,0,1,0 on a 2-beat packet from port 3.
        clr();
        load(3, 2);
        drive();
        step();
        m_tready = 1'b1; step();
        m_tready = 1'b0; step();
        m_tready = 1'b1; step();
        m_tready = 1'b0; step();
        m_tready = 1'b1;
        chk("bp_rhist", 64'(rh[19:0]), 64'h08080);
        chk("bp_vhist", 64'(vh[4:0]), 64'h0E);
        chk("bp_nbeats", 64'(out_q.size()), 64'd2);
        chk_out(0, 3, 0, 2);
        chk_out(1, 3, 1, 2);

        // Granted source stalls for three cycles mid-packet.
        clr();
        load(0, 3);
        drive();
        repeat (2) step();
        en[0] = 1'b0;
        drive();
        repeat (3) step();
        en[0] = 1'b1;
        drive();
        repeat (2) step();
        chk("stall_vhist", 64'(vh[6:0]), 64'h23);
        chk("stall_ghist", 64'(gh[27:0]), 64'h0111111);
        chk("stall_nbeats", 64'(out_q.size()), 64'd3);
        for (int unsigned b = 0; b < 3; b++) chk_out(b, 0, b, 3);

        // Reset during beat 2 of a 5-beat packet from port 1.
        clr();
        load(1, 5);
        drive();
        repeat (3) step();
        reset  = 1'b1;
        len[1] = 0;
        drive();
        @(negedge clk);
        chk("rabort_mvalid", 64'(m_tvalid), 64'd0);
        chk("rabort_grant", 64'(cur_grant), 64'd0);
        chk("rabort_sready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        clr();
        load(1, 1);
        load(0, 1);
        drive();
        repeat (4) step();
        chk("rpost_ghist", 64'(gh[15:0]), 64'h0102);
        chk_out(0, 0, 0, 1);
        chk_out(1, 1, 0, 1);

        // Five single-beat packets on port 1 after a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        clr();
        for (int i = 0; i < 5; i++) begin
            int n;
            n = 0;
            load(1, 1);
            drive();
            while (len[1] != 0 && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("cnt_pkt%0d_done", i), 64'(len[1]), 64'd0);
        end
        step();
        chk("cnt_nbeats", 64'(out_q.size()), 64'd5);
`ifdef PKT_RR_ARB_CNT_EN
        chk("cnt_slice1", 64'(pkt_cnt[63:32]), 64'd5);
        chk("cnt_others", 64'(|{pkt_cnt[127:64], pkt_cnt[31:0]}), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 Parameter: C_S_AXIS_DATA_WIDTH, default 256, tdata width per port.
REQ-002 Parameter: C_S_AXIS_TUSER_WIDTH, default 128, tuser width per port.
REQ-003 Parameter: NUM_PORTS, default 4, number of requesting AXIS inputs (2..8).
REQ-004 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  per-port data; port i occupies slice i.
REQ-007 Ports: s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  per-port byte enables.
REQ-008 Ports: s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  per-port metadata.
REQ-009 Ports: s_axis_tvalid  in  NUM_PORTS  per-port valid.
REQ-010 Ports: s_axis_tready  out  NUM_PORTS  per-port ready.
REQ-011 Ports: s_axis_tlast  in  NUM_PORTS  per-port end of packet.
REQ-012 Ports: m_axis_tdata/tkeep/tuser  out  C_S_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH/8 / C_S_AXIS_TUSER_WIDTH  merged stream to the stage pipeline.
REQ-013 Ports: m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.
REQ-014 Ports: cur_grant  out  NUM_PORTS  one-hot port currently owning the output; 0 when idle.

Function
REQ-015 Arbitration SHALL be packet-granular round-robin; a grant is held from first beat until the tlast beat is accepted.
REQ-016 FSM SHALL have states IDLE and FWD.
REQ-017 In IDLE with any s_axis_tvalid set: register grant to the first requesting port searching from (last_port+1) mod NUM_PORTS upward; go to FWD next cycle.
REQ-018 In IDLE: all s_axis_tready = 0, m_axis_tvalid = 0.
REQ-019 In FWD: m_axis_* SHALL combinationally equal the granted port's slice; s_axis_tready[g] = m_axis_tready; all other tready = 0.
REQ-020 In FWD, a beat transfers when s_axis_tvalid[g] && m_axis_tready; on a transferred beat with tlast = 1: last_port <= g, cur_grant <= 0, state <= IDLE.
REQ-021 Grant decision costs exactly one idle cycle between packets; first beat appears on m_axis one cycle after the IDLE cycle in which the request is seen.
REQ-022 tuser, tkeep, tdata SHALL pass unmodified; no beat is dropped, duplicated or reordered.
REQ-023 Granted port deasserting tvalid mid-packet: hold grant, m_axis_tvalid = 0, wait indefinitely.
REQ-024 Requests from non-granted ports during FWD SHALL be ignored until return to IDLE.
REQ-025 Single-beat packet (tlast on first beat) SHALL be forwarded and release grant in same transfer cycle.
REQ-026 Pointer wrap: last_port = NUM_PORTS-1 searches from port 0.

Reset
REQ-027 On reset: state = IDLE, cur_grant = 0, last_port = NUM_PORTS-1 (port 0 has first priority), all s_axis_tready = 0, m_axis_tvalid = 0.
REQ-028 Reset asserted mid-packet SHALL abort forwarding immediately; the partial packet is not resumed after reset.

Configuration
REQ-029 Macro PKT_RR_ARB_CNT_EN defined: adds output pkt_cnt (NUM_PORTS*32 bits), slice i incremented on each accepted tlast beat from port i, wraps at 2^32, cleared by reset.
REQ-030 Macro PKT_RR_ARB_CNT_EN undefined: pkt_cnt port and counters absent; all other behaviour identical.

Verification
REQ-031 Ports 0..3 each offer one 3-beat packet simultaneously after reset, m_axis_tready = 1 -> output order 0,1,2,3; 12 beats; one idle cycle between packets.
REQ-032 Port 2 sends 4-beat packet while port 1 raises tvalid at beat 2 -> port 2 packet completes contiguously, then port 1 granted; cur_grant = 4'b0100 then 4'b0010.
REQ-033 m_axis_tready toggles 1,0,1,0 during a 2-beat packet on port 3 -> s_axis_tready[3] mirrors it; exactly 2 beats out, tkeep/tuser bit-exact.
REQ-034 last_port = 3, ports 0 and 3 both request -> port 0 granted (wrap).
REQ-035 Reset asserted at beat 2 of 5-beat packet -> next cycle m_axis_tvalid = 0, cur_grant = 0; after release, port 0 wins first.
REQ-036 With PKT_RR_ARB_CNT_EN: 5 single-beat packets on port 1 -> pkt_cnt slice 1 = 5, others 0.
